// File: rtl/key_auth_unit.sv
`default_nettype none
// ============================================================================
// Module   : key_auth_unit
// Purpose  : Key authentication FSM feeding the memory/register security
//            stage. Releases the authorised key on key_access_mem/_reg only
//            while a session is open; enforces a consecutive-failure lockout
//            and an inactivity timeout on open sessions.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            key_in, key_valid  - key attempt (sampled only when key_ready)
//            access_active      - access in progress, restarts session timer
//            lock_req           - explicit relock while unlocked
//            key_ready          - high in LOCKED
//            key_access_mem/reg - KEY while UNLOCKED, else zero
//            unlocked/locked_out- state flags
//            auth_ok/auth_fail  - one-cycle result pulses
//            fail_count         - consecutive wrong-key count
// Revision : 1.0 - initial release
// ============================================================================
module key_auth_unit #(
  parameter logic [15:0] KEY            = 16'h0032,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 64,
  parameter int          SESSION_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_in,
  input  logic        key_valid,
  input  logic        access_active,
  input  logic        lock_req,
  output logic        key_ready,
  output logic [15:0] key_access_mem,
  output logic [15:0] key_access_reg,
  output logic        unlocked,
  output logic        locked_out,
  output logic        auth_ok,
  output logic        auth_fail,
  output logic [3:0]  fail_count
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int SW = $clog2(SESSION_CYCLES + 1);

  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
  localparam logic [1:0] ST_LOCKOUT  = 2'd2;

  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [SW-1:0] SESS_LOAD = SW'(SESSION_CYCLES);
  localparam logic [3:0]    FAIL_MAX  = 4'(MAX_FAILS);

  logic [1:0]    state_q,     state_d;
  logic [3:0]    fail_cnt_q,  fail_cnt_d;
  logic [LW-1:0] lock_tmr_q,  lock_tmr_d;
  logic [SW-1:0] sess_tmr_q,  sess_tmr_d;
  logic          auth_ok_q,   auth_ok_d;
  logic          auth_fail_q, auth_fail_d;
  logic [3:0]    fail_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOCKED;
      fail_cnt_q  <= 4'd0;
      lock_tmr_q  <= '0;
      sess_tmr_q  <= '0;
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_cnt_q  <= fail_cnt_d;
      lock_tmr_q  <= lock_tmr_d;
      sess_tmr_q  <= sess_tmr_d;
      auth_ok_q   <= auth_ok_d;
      auth_fail_q <= auth_fail_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    fail_cnt_d  = fail_cnt_q;
    lock_tmr_d  = lock_tmr_q;
    sess_tmr_d  = sess_tmr_q;
    auth_ok_d   = 1'b0;
    auth_fail_d = 1'b0;
    fail_inc    = fail_cnt_q + 4'd1;

    case (state_q)
      ST_LOCKED: begin
        if (key_valid) begin
          if (key_in == KEY) begin
            state_d    = ST_UNLOCKED;
            fail_cnt_d = 4'd0;
            sess_tmr_d = SESS_LOAD;
            auth_ok_d  = 1'b1;
          end else begin
            auth_fail_d = 1'b1;
            // Count saturates at FAIL_MAX because reaching it leaves LOCKED.
            fail_cnt_d  = fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state_d    = ST_LOCKOUT;
              lock_tmr_d = LOCK_LOAD;
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (lock_req) begin
          state_d = ST_LOCKED;
        end else if (access_active) begin
          sess_tmr_d = SESS_LOAD;
        end else if (sess_tmr_q != '0) begin
          sess_tmr_d = sess_tmr_q - 1'b1;
          if (sess_tmr_q == SW'(1)) begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        if (lock_tmr_q != '0) begin
          lock_tmr_d = lock_tmr_q - 1'b1;
          if (lock_tmr_q == LW'(1)) begin
            state_d    = ST_LOCKED;
            fail_cnt_d = 4'd0;
          end
        end else begin
          state_d    = ST_LOCKED;
          fail_cnt_d = 4'd0;
        end
      end

      default: begin
        // Unreachable encoding: fall back to the safe state.
        state_d    = ST_LOCKED;
        fail_cnt_d = 4'd0;
      end
    endcase
  end

  // Outputs, decoded purely from registers
  always_comb begin
    key_ready      = (state_q == ST_LOCKED);
    unlocked       = (state_q == ST_UNLOCKED);
    locked_out     = (state_q == ST_LOCKOUT);
    key_access_mem = (state_q == ST_UNLOCKED) ? KEY : 16'h0000;
    key_access_reg = (state_q == ST_UNLOCKED) ? KEY : 16'h0000;
    auth_ok        = auth_ok_q;
    auth_fail      = auth_fail_q;
    fail_count     = fail_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_auth_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_auth_unit
// Purpose  : Self-checking bench for key_auth_unit. Stimulus pushes expected
//            per-cycle outputs from a deadline-based reference model into a
//            scoreboard queue; a monitor pops and compares after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_auth_unit;

  localparam logic [15:0] KEY  = 16'h0032;
  localparam int          MAXF = 3;
  localparam int          LOCKC = 64;
  localparam int          SESS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_in = 16'h0000;
  logic        key_valid = 1'b0;
  logic        access_active = 1'b0;
  logic        lock_req = 1'b0;
  logic        key_ready;
  logic [15:0] key_access_mem;
  logic [15:0] key_access_reg;
  logic        unlocked;
  logic        locked_out;
  logic        auth_ok;
  logic        auth_fail;
  logic [3:0]  fail_count;

  always #5 clk = ~clk;

  key_auth_unit #(
    .KEY(KEY), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCKC), .SESSION_CYCLES(SESS)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .access_active(access_active), .lock_req(lock_req),
    .key_ready(key_ready), .key_access_mem(key_access_mem),
    .key_access_reg(key_access_reg), .unlocked(unlocked),
    .locked_out(locked_out), .auth_ok(auth_ok), .auth_fail(auth_fail),
    .fail_count(fail_count)
  );

  typedef enum int {M_LOCKED, M_UNLOCKED, M_LOCKOUT} mode_t;

  typedef struct {
    logic        ready;
    logic [15:0] kmem;
    logic [15:0] kreg;
    logic        unl;
    logic        lko;
    logic        ok;
    logic        fl;
    logic [3:0]  fc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode plus an absolute edge number at which the current
  // timed state expires.
  mode_t  m_mode = M_LOCKED;
  int     m_fails = 0;
  longint m_edge = 0;
  longint m_deadline = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("key_ready",      16'(key_ready),  16'(e.ready));
        chk("key_access_mem", key_access_mem,  e.kmem);
        chk("key_access_reg", key_access_reg,  e.kreg);
        chk("unlocked",       16'(unlocked),   16'(e.unl));
        chk("locked_out",     16'(locked_out), 16'(e.lko));
        chk("auth_ok",        16'(auth_ok),    16'(e.ok));
        chk("auth_fail",      16'(auth_fail),  16'(e.fl));
        chk("fail_count",     16'(fail_count), 16'(e.fc));
      end
    end
  end

  // Drive one cycle of inputs, advance the model across the coming edge and
  // queue the outputs expected after it.
  task automatic step(input logic r, input logic kv, input logic [15:0] k,
                      input logic acc, input logic lr);
    exp_t e;
    logic ok, fl;
    @(negedge clk);
    rst = r; key_valid = kv; key_in = k; access_active = acc; lock_req = lr;
    m_edge++;
    ok = 1'b0;
    fl = 1'b0;
    if (r) begin
      m_mode  = M_LOCKED;
      m_fails = 0;
    end else begin
      case (m_mode)
        M_LOCKED: begin
          if (kv) begin
            if (k == KEY) begin
              m_mode     = M_UNLOCKED;
              m_fails    = 0;
              m_deadline = m_edge + SESS;
              ok         = 1'b1;
            end else begin
              fl = 1'b1;
              m_fails++;
              if (m_fails == MAXF) begin
                m_mode     = M_LOCKOUT;
                m_deadline = m_edge + LOCKC;
              end
            end
          end
        end
        M_UNLOCKED: begin
          if (lr)                       m_mode = M_LOCKED;
          else if (acc)                 m_deadline = m_edge + SESS;
          else if (m_edge == m_deadline) m_mode = M_LOCKED;
        end
        M_LOCKOUT: begin
          if (m_edge == m_deadline) begin
            m_mode  = M_LOCKED;
            m_fails = 0;
          end
        end
        default: m_mode = M_LOCKED;
      endcase
    end
    e.ready = (m_mode == M_LOCKED);
    e.unl   = (m_mode == M_UNLOCKED);
    e.lko   = (m_mode == M_LOCKOUT);
    e.kmem  = e.unl ? KEY : 16'h0000;
    e.kreg  = e.unl ? KEY : 16'h0000;
    e.ok    = ok;
    e.fl    = fl;
    e.fc    = 4'(m_fails);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [15:0] k);
    step(1'b0, 1'b1, k, 1'b0, 1'b0);
  endtask

  initial begin
    int wait_cnt;
    // Reset state
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, KEY, 1'b1, 1'b1);

    // Correct key, wrong key ignored while unlocked, lock_req beats access
    key(KEY);
    idle(3);
    key(16'h1111);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    idle(2);

    // Lockout, correct key ignored during it
    key(16'h1111); key(16'h2222); key(16'h3333);
    key(KEY);
    idle(70);

    // Two wrong keys then correct clears the count
    key(16'h1111); key(16'h2222); key(KEY);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    key(16'h4444); key(16'h5555); key(16'h6666);
    idle(66);

    // Session timeout with no activity
    key(KEY);
    idle(1030);

    // Access at idle cycle 1000 restarts the session count
    key(KEY);
    idle(999);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(1030);

    // Correct key together with lock_req/access in LOCKED: key wins
    step(1'b0, 1'b1, KEY, 1'b1, 1'b1);
    idle(2);

    // Reset mid-UNLOCKED and mid-LOCKOUT
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(2);
    key(16'h0001); key(16'h0002); key(16'h0003);
    idle(10);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, kv, acc, lr;
      logic [15:0] k;
      r   = ($urandom_range(0, 199) == 0);
      kv  = ($urandom_range(0, 1) == 1);
      k   = ($urandom_range(0, 2) == 0) ? KEY : 16'($urandom);
      acc = ($urandom_range(0, 15) == 0);
      lr  = ($urandom_range(0, 31) == 0);
      step(r, kv, k, acc, lr);
    end

    // Drain the scoreboard with a bounded wait
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_auth_unit.md
# key_auth_unit

Key authentication FSM directly upstream of the memory/register security stage. It accepts 16-bit key attempts and drives `key_access_mem` / `key_access_reg` with the authorised key only while a session is open, so the security stage encrypts and decrypts only for authenticated sessions. It enforces a failed-attempt lockout and an inactivity session timeout.

## Interface
- `KEY`, 16'h0032, the authorised key value. It is also the value driven on both key outputs while unlocked.
- `MAX_FAILS`, 3, number of consecutive wrong keys that triggers lockout. Range 1..15.
- `LOCKOUT_CYCLES`, 64, number of cycles spent in LOCKOUT. Must be ≥1.
- `SESSION_CYCLES`, 1024, number of idle cycles before an open session auto-relocks. Must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_in`  in  16  key attempt.
- `key_valid`  in  1  qualifies `key_in`. Sampled only when `key_ready`=1.
- `access_active`  in  1  a memory or register access is in progress; reloads the session timer.
- `lock_req`  in  1  explicit relock request.
- `key_ready`  out  1  high in LOCKED only.
- `key_access_mem`  out  16  equals `KEY` in UNLOCKED, otherwise 16'h0000.
- `key_access_reg`  out  16  equals `KEY` in UNLOCKED, otherwise 16'h0000.
- `unlocked`  out  1  state==UNLOCKED.
- `locked_out`  out  1  state==LOCKOUT.
- `auth_ok`  out  1  one-cycle pulse on a correct key.
- `auth_fail`  out  1  one-cycle pulse on a wrong key.
- `fail_count`  out  4  consecutive wrong-key count.

## Operation
- States are LOCKED, UNLOCKED and LOCKOUT. All outputs are decoded from registers; there is no combinational path from inputs to outputs.
- Reset forces:
  - state=LOCKED, fail_count=0, both timers=0, auth_ok=auth_fail=0;
  - so key_ready=1, key_access_*=16'h0000, unlocked=0, locked_out=0.
- LOCKED, with `key_valid`=1:
  - `key_in`==KEY: go to UNLOCKED, fail_count←0, session timer←SESSION_CYCLES, auth_ok pulses.
  - Otherwise auth_fail pulses and fail_count←fail_count+1.
  - If the new count equals MAX_FAILS: go to LOCKOUT with lockout timer←LOCKOUT_CYCLES. fail_count holds MAX_FAILS during LOCKOUT.
- LOCKED, with `key_valid`=0: hold. `access_active` and `lock_req` have no effect.
- UNLOCKED:
  - `key_valid` is ignored: no pulses and no count change.
  - Priority order:
    1. `lock_req`: go to LOCKED.
    2. `access_active`: session timer←SESSION_CYCLES.
    3. Otherwise decrement the session timer. When the timer is 1 and decrements, go to LOCKED.
  - Leaving UNLOCKED does not change fail_count.
- LOCKOUT:
  - `key_valid`, `lock_req` and `access_active` are ignored.
  - The lockout timer decrements every cycle. When it is 1 and decrements: go to LOCKED and fail_count←0.
- Timer widths are $clog2(param+1) bits. Timers never underflow. A timer is not modified outside its own state.
- fail_count never exceeds MAX_FAILS and never wraps.
- Mid-operation `rst` overrides everything in any state and returns the block to reset values on the next edge.

## Timing
- A key sampled at edge N: unlocked/key_access_*/auth_ok are visible after edge N, in cycle N+1. auth_ok and auth_fail are high for exactly that one cycle.
- A correct key at edge N with no further activity:
  - UNLOCKED occupies exactly SESSION_CYCLES cycles;
  - state is LOCKED after edge N+SESSION_CYCLES.
- `access_active` at edge M restarts the count: LOCKED after edge M+SESSION_CYCLES, if there is no further activity.
- `lock_req` at edge M: LOCKED and key_access_*=0 after edge M (latency 1).
- The MAX_FAILS-th wrong key at edge N:
  - LOCKOUT after edge N;
  - LOCKED again after edge N+LOCKOUT_CYCLES;
  - key_ready is 0 for exactly LOCKOUT_CYCLES cycles.
- Back-to-back attempts: one attempt per cycle is accepted while in LOCKED. An attempt in the same cycle that causes a state exit is the last one processed in that state.
- Same edge as a correct key, `lock_req` and `access_active`: the key wins, because those inputs have no effect in LOCKED.

## Test plan
- After reset, key_in=16'h0032 with key_valid for 1 cycle -> next cycle: unlocked=1, key_access_mem=key_access_reg=16'h0032, auth_ok=1 for 1 cycle, fail_count=0.
- Keys 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> auth_fail pulses each cycle, fail_count 1,2,3, locked_out=1 after the third edge. A correct key during LOCKOUT is ignored. locked_out=1 for exactly 64 cycles, then key_ready=1 and fail_count=0.
- Two wrong keys, then 16'h0032 -> unlocked, fail_count=0. Three more wrong keys are still needed to reach lockout.
- Unlock with no activity -> unlocked stays 1 for exactly 1024 cycles, then key_access_*=0. Repeat with access_active pulsed at idle cycle 1000 -> relock occurs 1024 cycles after the pulse.
- Unlocked, lock_req and access_active asserted together -> LOCKED next cycle (lock_req wins). key_valid with a wrong key while unlocked -> no auth_fail and no count change.
- rst asserted mid-LOCKOUT and mid-UNLOCKED -> all outputs at reset values on the next cycle, fail_count=0.
